// File: rtl/oflow_iou_sched_pkg.sv
// Shared types and constants for the optical-flow IoU scheduler.
// Holds FSM state codes, the all-ones cost constant and the history entry layout.
package oflow_iou_sched_pkg;

    localparam int IDX_W_D   = 4;
    localparam int BBOX_W_D  = 44;
    localparam int DIM_W_D   = 11;
    localparam int IOU_LEN_D = 22;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_CMP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [IOU_LEN_D-1:0] COST_MAX = '1;

    typedef struct packed {
        logic [BBOX_W_D-1:0] bbox;
        logic [DIM_W_D-1:0]  w;
        logic [DIM_W_D-1:0]  h;
    } hist_entry_t;

endpackage

// File: rtl/oflow_iou_best_tracker.sv
// Keeps the lowest accepted IoU cost and its history index.
// Ports: clear (restart search), update (candidate present), idx/cost (candidate),
// thresh (acceptance ceiling), best_idx/best_cost/found (registered result).
module oflow_iou_best_tracker #(
    parameter int IDX_W   = 4,
    parameter int IOU_LEN = 22
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               clear,
    input  logic               update,
    input  logic [IDX_W-1:0]   idx,
    input  logic [IOU_LEN-1:0] cost,
    input  logic [IOU_LEN-1:0] thresh,
    output logic [IDX_W-1:0]   best_idx,
    output logic [IOU_LEN-1:0] best_cost,
    output logic               found
);

    logic accept;

    // Strict less-than: on a tie the earlier (lower) index is kept.
    assign accept = update && (cost < best_cost) && (cost <= thresh);

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            best_idx  <= '0;
            best_cost <= '1;
            found     <= 1'b0;
        end else if (clear) begin
            best_idx  <= '0;
            best_cost <= '1;
            found     <= 1'b0;
        end else if (accept) begin
            best_idx  <= idx;
            best_cost <= cost;
            found     <= 1'b1;
        end
    end

endmodule

// File: rtl/oflow_iou_scheduler.sv
// Sequences the shared IoU-cost unit over the history bboxes of one frame-k bbox
// and reports the lowest-cost match.
// Ports: start/num_hist/bbox_k/w_k/h_k request; hist_rd_* history RF read
// (1-cycle latency); iou_* IoU unit operands, start and result; busy/done and
// best_idx/best_cost/no_match/timeout_err result. All outputs are registered.
// Option: OFLOW_IOU_SCHED_THRESH_EN adds cost_thresh, an acceptance ceiling.
module oflow_iou_scheduler
    import oflow_iou_sched_pkg::*;
#(
    parameter int MAX_HIST = 16,
    parameter int IDX_W    = 4,
    parameter int BBOX_W   = 44,
    parameter int DIM_W    = 11,
    parameter int IOU_LEN  = 22,
    parameter int TIMEOUT  = 32
) (
    input  logic               clk,
    input  logic               reset_N,
`ifdef OFLOW_IOU_SCHED_THRESH_EN
    input  logic [IOU_LEN-1:0] cost_thresh,
`endif
    input  logic               start,
    input  logic [IDX_W:0]     num_hist,
    input  logic [BBOX_W-1:0]  bbox_k,
    input  logic [DIM_W-1:0]   w_k,
    input  logic [DIM_W-1:0]   h_k,
    output logic               hist_rd_en,
    output logic [IDX_W-1:0]   hist_rd_addr,
    input  logic [BBOX_W-1:0]  hist_rd_bbox,
    input  logic [DIM_W-1:0]   hist_rd_w,
    input  logic [DIM_W-1:0]   hist_rd_h,
    output logic               iou_start,
    output logic [BBOX_W-1:0]  iou_bbox_k,
    output logic [DIM_W-1:0]   iou_w_k,
    output logic [DIM_W-1:0]   iou_h_k,
    output logic [BBOX_W-1:0]  iou_bbox_hist,
    output logic [DIM_W-1:0]   iou_w_hist,
    output logic [DIM_W-1:0]   iou_h_hist,
    input  logic               iou_valid,
    input  logic [IOU_LEN-1:0] iou_cost,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   best_idx,
    output logic [IOU_LEN-1:0] best_cost,
    output logic               no_match,
    output logic               timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   HIST_LIM  = (IDX_W + 1)'(MAX_HIST);

    logic [2:0]         state;
    logic [IDX_W:0]     idx;
    logic [IDX_W:0]     idx_inc;
    logic [IDX_W:0]     num_q;
    logic [CNT_W-1:0]   wcnt;
    logic [IOU_LEN-1:0] cost_q;
    hist_entry_t        hist_q;
    logic               found;
    logic               trk_clear;
    logic               trk_update;
    logic [IOU_LEN-1:0] thresh;

`ifdef OFLOW_IOU_SCHED_THRESH_EN
    assign thresh = cost_thresh;
`else
    assign thresh = '1;
`endif

    // idx is one bit wider than the address so num_hist = MAX_HIST ends cleanly.
    assign idx_inc    = idx + {{IDX_W{1'b0}}, 1'b1};
    assign trk_clear  = (state == S_IDLE) && start;
    assign trk_update = (state == S_CMP);

    assign iou_bbox_hist = hist_q.bbox;
    assign iou_w_hist    = hist_q.w;
    assign iou_h_hist    = hist_q.h;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state        <= S_IDLE;
            idx          <= '0;
            num_q        <= '0;
            wcnt         <= '0;
            cost_q       <= '0;
            hist_q       <= '0;
            hist_rd_en   <= 1'b0;
            hist_rd_addr <= '0;
            iou_start    <= 1'b0;
            iou_bbox_k   <= '0;
            iou_w_k      <= '0;
            iou_h_k      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            no_match     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            hist_rd_en <= 1'b0;
            iou_start  <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_q       <= (num_hist > HIST_LIM) ? HIST_LIM : num_hist;
                        iou_bbox_k  <= bbox_k;
                        iou_w_k     <= w_k;
                        iou_h_k     <= h_k;
                        idx         <= '0;
                        timeout_err <= 1'b0;
                        no_match    <= 1'b0;
                        busy        <= 1'b1;
                        if (num_hist == '0) begin
                            state <= S_DONE;
                        end else begin
                            state        <= S_FETCH;
                            hist_rd_en   <= 1'b1;
                            hist_rd_addr <= '0;
                        end
                    end
                end
                // Read strobe is raised on entry, so FETCH only decides
                // whether the list is exhausted.
                S_FETCH: begin
                    state <= (idx == num_q) ? S_DONE : S_LOAD;
                end
                S_LOAD: begin
                    hist_q    <= {hist_rd_bbox, hist_rd_w, hist_rd_h};
                    iou_start <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (iou_valid) begin
                        cost_q <= iou_cost;
                        state  <= S_CMP;
                    end else if (wcnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_CMP: begin
                    idx   <= idx_inc;
                    state <= S_FETCH;
                    if (idx_inc != num_q) begin
                        hist_rd_en   <= 1'b1;
                        hist_rd_addr <= idx_inc[IDX_W-1:0];
                    end
                end
                S_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    no_match <= ~found;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    oflow_iou_best_tracker #(
        .IDX_W   (IDX_W),
        .IOU_LEN (IOU_LEN)
    ) u_best (
        .clk       (clk),
        .reset_N   (reset_N),
        .clear     (trk_clear),
        .update    (trk_update),
        .idx       (idx[IDX_W-1:0]),
        .cost      (cost_q),
        .thresh    (thresh),
        .best_idx  (best_idx),
        .best_cost (best_cost),
        .found     (found)
    );

endmodule

// File: tb/tb_oflow_iou_scheduler.sv
// Directed self-checking bench for oflow_iou_scheduler.
// Models a history RF (1-cycle read) and an IoU unit with 4-cycle latency.
module tb_oflow_iou_scheduler;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset_N = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  num_hist = '0;
    logic [43:0] bbox_k = '0;
    logic [10:0] w_k = '0;
    logic [10:0] h_k = '0;
    logic        hist_rd_en;
    logic [3:0]  hist_rd_addr;
    logic [43:0] hist_rd_bbox = '0;
    logic [10:0] hist_rd_w = '0;
    logic [10:0] hist_rd_h = '0;
    logic        iou_start;
    logic [43:0] iou_bbox_k;
    logic [10:0] iou_w_k;
    logic [10:0] iou_h_k;
    logic [43:0] iou_bbox_hist;
    logic [10:0] iou_w_hist;
    logic [10:0] iou_h_hist;
    logic        iou_valid = 1'b0;
    logic [21:0] iou_cost = '0;
    logic        busy;
    logic        done;
    logic [3:0]  best_idx;
    logic [21:0] best_cost;
    logic        no_match;
    logic        timeout_err;
`ifdef OFLOW_IOU_SCHED_THRESH_EN
    logic [21:0] cost_thresh = '1;
`endif

    logic [43:0] m_bbox [16];
    logic [10:0] m_w [16];
    logic [10:0] m_h [16];
    logic [21:0] cost_tab [16];
    bit          hang0 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    oflow_iou_scheduler dut (
        .clk           (clk),
        .reset_N       (reset_N),
`ifdef OFLOW_IOU_SCHED_THRESH_EN
        .cost_thresh   (cost_thresh),
`endif
        .start         (start),
        .num_hist      (num_hist),
        .bbox_k        (bbox_k),
        .w_k           (w_k),
        .h_k           (h_k),
        .hist_rd_en    (hist_rd_en),
        .hist_rd_addr  (hist_rd_addr),
        .hist_rd_bbox  (hist_rd_bbox),
        .hist_rd_w     (hist_rd_w),
        .hist_rd_h     (hist_rd_h),
        .iou_start     (iou_start),
        .iou_bbox_k    (iou_bbox_k),
        .iou_w_k       (iou_w_k),
        .iou_h_k       (iou_h_k),
        .iou_bbox_hist (iou_bbox_hist),
        .iou_w_hist    (iou_w_hist),
        .iou_h_hist    (iou_h_hist),
        .iou_valid     (iou_valid),
        .iou_cost      (iou_cost),
        .busy          (busy),
        .done          (done),
        .best_idx      (best_idx),
        .best_cost     (best_cost),
        .no_match      (no_match),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // History register file, 1-cycle read latency.
    always @(posedge clk) begin
        if (hist_rd_en) begin
            hist_rd_bbox <= m_bbox[hist_rd_addr];
            hist_rd_w    <= m_w[hist_rd_addr];
            hist_rd_h    <= m_h[hist_rd_addr];
        end
    end

    // IoU unit: valid L cycles after the cycle iou_start is high.
    // Entry index is carried in the low bits of each history bbox.
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [21:0] cur = '0;

    always @(posedge clk) begin
        iou_valid <= 1'b0;
        if (iou_start && !(hang0 && iou_bbox_hist[3:0] == 4'd0)) begin
            pend <= 1'b1;
            cnt  <= 1;
            cur  <= cost_tab[iou_bbox_hist[3:0]];
        end else if (pend) begin
            if (cnt == L - 1) begin
                iou_valid <= 1'b1;
                iou_cost  <= cur;
                pend      <= 1'b0;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    // Operands presented with each start must match the entry and the request.
    always @(negedge clk) begin
        if (iou_start) begin
            chk("op_w_hist", 64'(iou_w_hist), 64'(m_w[iou_bbox_hist[3:0]]));
            chk("op_h_hist", 64'(iou_h_hist), 64'(m_h[iou_bbox_hist[3:0]]));
            chk("op_bbox_k", 64'(iou_bbox_k), 64'h123456789AB);
            chk("op_wk_hk", 64'({iou_w_k, iou_h_k}), 64'({11'd77, 11'd33}));
        end
    end

    // Issues one request; cycles counted from the start cycle to the done cycle.
    task automatic run_req(input int n, input bit poke, output int lat,
                           output int n_iss, output int n_rd, output bit wide);
        bit prev;
        prev  = 1'b0;
        lat   = 0;
        n_iss = 0;
        n_rd  = 0;
        wide  = 1'b0;
        @(negedge clk);
        num_hist = 5'(n);
        start    = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start    = 1'b0;
                num_hist = 5'd9;
            end
            if (poke && lat == 6) start = 1'b1;
            if (poke && lat == 7) start = 1'b0;
            if (iou_start) begin
                n_iss++;
                if (prev) wide = 1'b1;
            end
            prev = iou_start;
            if (hist_rd_en) n_rd++;
            if (done) break;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int lat;
        int n_iss;
        int n_rd;
        bit wide;
        int nd;

        for (int i = 0; i < 16; i++) begin
            m_bbox[i]   = {11'(i + 1), 11'(2 * i + 3), 11'(i + 40), 11'(i)};
            m_w[i]      = 11'(100 + i);
            m_h[i]      = 11'(50 + i);
            cost_tab[i] = 22'h3F0000;
        end
        bbox_k = 44'h123456789AB;
        w_k    = 11'd77;
        h_k    = 11'd33;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_best_cost", 64'(best_cost), 64'h3FFFFF);
        chk("rst_best_idx", 64'(best_idx), 64'd0);
        chk("rst_flags", 64'({no_match, timeout_err}), 64'd0);
        chk("rst_strobes", 64'({iou_start, hist_rd_en}), 64'd0);
        reset_N = 1'b1;
        repeat (2) @(negedge clk);

        // Basic three-entry search.
        cost_tab[0] = 22'h200000;
        cost_tab[1] = 22'h100000;
        cost_tab[2] = 22'h300000;
        run_req(3, 1'b0, lat, n_iss, n_rd, wide);
        chk("t1_latency", 64'(lat), 64'd27);
        chk("t1_best_idx", 64'(best_idx), 64'd1);
        chk("t1_best_cost", 64'(best_cost), 64'h100000);
        chk("t1_no_match", 64'(no_match), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_starts", 64'(n_iss), 64'd3);
        chk("t1_reads", 64'(n_rd), 64'd3);
        @(negedge clk);
        chk("t1_done_1cyc", 64'(done), 64'd0);
        chk("t1_hold_cost", 64'(best_cost), 64'h100000);

        // Empty history list.
        run_req(0, 1'b0, lat, n_iss, n_rd, wide);
        chk("t2_latency", 64'(lat), 64'd2);
        chk("t2_no_match", 64'(no_match), 64'd1);
        chk("t2_best_cost", 64'(best_cost), 64'h3FFFFF);
        chk("t2_best_idx", 64'(best_idx), 64'd0);
        chk("t2_strobes", 64'(n_iss + n_rd), 64'd0);

        // Tie resolution plus a start pulse while busy.
        cost_tab[0] = 22'h50;
        cost_tab[1] = 22'h10;
        cost_tab[2] = 22'h10;
        cost_tab[3] = 22'h60;
        run_req(4, 1'b1, lat, n_iss, n_rd, wide);
        chk("t3_latency", 64'(lat), 64'd35);
        chk("t3_best_idx", 64'(best_idx), 64'd1);
        chk("t3_best_cost", 64'(best_cost), 64'h10);
        chk("t3_starts", 64'(n_iss), 64'd4);
        chk("t3_start_width", 64'(wide), 64'd0);
        nd = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("t3_extra_done", 64'(nd), 64'd0);

        // IoU unit never answers entry 0.
        hang0 = 1'b1;
        cost_tab[0] = 22'h5;
        run_req(2, 1'b0, lat, n_iss, n_rd, wide);
        chk("t4_latency", 64'(lat), 64'd37);
        chk("t4_timeout", 64'(timeout_err), 64'd1);
        chk("t4_no_match", 64'(no_match), 64'd1);
        chk("t4_best_idx", 64'(best_idx), 64'd0);
        chk("t4_best_cost", 64'(best_cost), 64'h3FFFFF);
        chk("t4_starts", 64'(n_iss), 64'd1);
        hang0 = 1'b0;
        @(negedge clk);
        chk("t4_sticky", 64'(timeout_err), 64'd1);

        cost_tab[0] = 22'h1234;
        run_req(1, 1'b0, lat, n_iss, n_rd, wide);
        chk("t5_latency", 64'(lat), 64'd11);
        chk("t5_timeout_clr", 64'(timeout_err), 64'd0);
        chk("t5_best_cost", 64'(best_cost), 64'h1234);
        chk("t5_no_match", 64'(no_match), 64'd0);

        // Reset during WAIT of entry 2 (cycles 20..23 after start).
        cost_tab[0] = 22'h7;
        cost_tab[1] = 22'h6;
        cost_tab[2] = 22'h5;
        @(negedge clk);
        num_hist = 5'd3;
        start    = 1'b1;
        n_iss    = 0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (iou_start) n_iss++;
        end
        chk("t6_starts_before", 64'(n_iss), 64'd3);
        chk("t6_busy_before", 64'(busy), 64'd1);
        reset_N = 1'b0;
        #1;
        chk("t6_rst_outs", 64'({busy, done, iou_start}), 64'd0);
        chk("t6_rst_cost", 64'(best_cost), 64'h3FFFFF);
        @(negedge clk);
        chk("t6_rst_start", 64'(iou_start), 64'd0);
        reset_N = 1'b1;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy || iou_start) nd++;
        end
        chk("t6_quiet", 64'(nd), 64'd0);
        run_req(3, 1'b0, lat, n_iss, n_rd, wide);
        chk("t6_latency", 64'(lat), 64'd27);
        chk("t6_best_idx", 64'(best_idx), 64'd2);
        chk("t6_best_cost", 64'(best_cost), 64'h5);

`ifdef OFLOW_IOU_SCHED_THRESH_EN
        cost_thresh = 22'h80;
        cost_tab[0] = 22'h90;
        cost_tab[1] = 22'hA0;
        run_req(2, 1'b0, lat, n_iss, n_rd, wide);
        chk("t7_no_match", 64'(no_match), 64'd1);
        chk("t7_best_cost", 64'(best_cost), 64'h3FFFFF);
        chk("t7_best_idx", 64'(best_idx), 64'd0);
        cost_tab[1] = 22'h40;
        run_req(2, 1'b0, lat, n_iss, n_rd, wide);
        chk("t7b_no_match", 64'(no_match), 64'd0);
        chk("t7b_best_idx", 64'(best_idx), 64'd1);
        chk("t7b_best_cost", 64'(best_cost), 64'h40);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oflow_iou_scheduler.md
Name: oflow_iou_scheduler

Overview:
- Sequences the shared IoU-cost datapath (oflow_calc_iou) for one frame-k bbox against up to MAX_HIST history bboxes.
- Fetches each history entry from the history register file, drives operands, pulses start, waits for valid_iou, and keeps the lowest cost (1−IoU, q0.22).
- Reports best history index, best cost and match status to the matching stage of the optical-flow pipeline.

Parameters:
- MAX_HIST, 16, maximum history bboxes per frame-k bbox.
- IDX_W, 4, history index width; must equal clog2(MAX_HIST).
- BBOX_W, 44, packed bbox width {X_TL, Y_TL, X_BR, Y_BR}, 11 bits each.
- DIM_W, 11, width/height field width.
- IOU_LEN, 22, cost width (q0.22).
- TIMEOUT, 32, maximum WAIT cycles before the request is aborted.

Ports:
- clk  in  1  clock.
- reset_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_hist  in  IDX_W+1  number of valid history entries, 0..MAX_HIST; latched on start.
- bbox_k  in  BBOX_W  frame-k bbox; latched on start.
- w_k  in  DIM_W  frame-k width; latched on start.
- h_k  in  DIM_W  frame-k height; latched on start.
- hist_rd_en  out  1  history read strobe.
- hist_rd_addr  out  IDX_W  history read index.
- hist_rd_bbox  in  BBOX_W  history bbox; 1-cycle read latency.
- hist_rd_w  in  DIM_W  history width; 1-cycle read latency.
- hist_rd_h  in  DIM_W  history height; 1-cycle read latency.
- iou_start  out  1  one-cycle start pulse to the IoU unit.
- iou_bbox_k  out  BBOX_W  operand to the IoU unit.
- iou_w_k  out  DIM_W  operand to the IoU unit.
- iou_h_k  out  DIM_W  operand to the IoU unit.
- iou_bbox_hist  out  BBOX_W  operand to the IoU unit.
- iou_w_hist  out  DIM_W  operand to the IoU unit.
- iou_h_hist  out  DIM_W  operand to the IoU unit.
- iou_valid  in  1  IoU unit result strobe.
- iou_cost  in  IOU_LEN  IoU unit result.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- best_idx  out  IDX_W  index of the lowest cost.
- best_cost  out  IOU_LEN  lowest cost.
- no_match  out  1  no candidate accepted.
- timeout_err  out  1  a WAIT exceeded TIMEOUT; sticky until the next start.

Behaviour:
- Reset values: all outputs 0, except best_cost = all-ones. FSM goes to IDLE, idx = 0.
- Reset asserted mid-operation: the request is abandoned, nothing is reported, and iou_start is 0 from reset onward.
- Registered outputs: all outputs are registered. Operand outputs stay stable from LOAD until the cycle after iou_valid, because the IoU unit samples operands across several states.
- IDLE:
  - start=1 latches bbox_k, w_k, h_k and num_hist, sets best_cost = all-ones, best_idx = 0, clears timeout_err and no_match.
  - Goes to FETCH, or to DONE if num_hist = 0.
  - start while busy is ignored.
- FETCH: hist_rd_en=1, hist_rd_addr=idx, go to LOAD.
- LOAD: latch hist_rd_* into the operand registers, go to ISSUE.
- ISSUE: iou_start=1 for exactly one cycle, WAIT counter cleared, go to WAIT.
- WAIT:
  - iou_valid=1: capture iou_cost, go to CMP.
  - Counter reaches TIMEOUT: set timeout_err=1, go to DONE with the current best values.
  - iou_valid while not in WAIT is ignored.
- CMP:
  - Update best only if cost < best_cost (strict), so on a tie the lower index wins.
  - idx = idx+1. If idx == num_hist go to DONE, else go to FETCH.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
  - no_match=1 when no candidate was accepted (num_hist=0, or timeout before the first result); best_idx is then 0.
  - best_* outputs hold until the next start.
- Latency: with IoU unit latency L (start to valid), done arrives 3 + num_hist·(4+L) cycles after start; num_hist=0 gives done 2 cycles after start.
- Index wrap: idx is IDX_W+1 bits, so num_hist = MAX_HIST terminates without wrapping.

Optional Feature:
- Macro: OFLOW_IOU_SCHED_THRESH_EN.
- With the macro defined:
  - Adds input cost_thresh [IOU_LEN-1:0].
  - A candidate is accepted only if cost <= cost_thresh and cost < best_cost.
  - If no candidate is accepted, no_match=1, best_cost = all-ones, best_idx=0.
- Without it: every valid result is a candidate; no_match=1 only for num_hist=0 or a timeout before the first result.

Decomposition:
- Package oflow_iou_sched_pkg holds:
  - the state enum {IDLE, FETCH, LOAD, ISSUE, WAIT, CMP, DONE};
  - the COST_MAX constant (all-ones, IOU_LEN);
  - a packed struct for the history entry {bbox, w, h}.
- One natural sub-module, oflow_iou_best_tracker: comparator plus best_idx/best_cost registers, with clear, update-enable and threshold inputs.
- The FSM, counters and operand registers stay in the top.

Test Plan:
- Bench IoU model with L=4; num_hist=3; costs 0x200000, 0x100000, 0x300000 -> done at cycle 3+3·8=27, best_idx=1, best_cost=0x100000, no_match=0.
- num_hist=0 -> done 2 cycles after start, no_match=1, best_cost=0x3FFFFF, no hist_rd_en or iou_start pulses.
- Tie: num_hist=4; costs 0x50, 0x10, 0x10, 0x60 -> best_idx=1; exactly 4 iou_start pulses, each one cycle wide.
- Model never asserts iou_valid on entry 0 -> timeout_err=1 after 32 WAIT cycles, done pulse, no_match=1; next start clears timeout_err.
- Reset_N low during WAIT of entry 2 -> busy, done and iou_start are 0, best_cost = all-ones; a new start afterwards completes normally. Also: a start pulse while busy is ignored and produces no second done.
- THRESH_EN, cost_thresh=0x80; costs 0x90, 0xA0 -> no_match=1. Same run with the second cost at 0x40 -> best_idx=1, best_cost=0x40.
